// File: rtl/mem_access_unit_pkg.sv
// Shared types and decode helpers for the load/store unit.
package mem_access_unit_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } lsu_state_t;

    typedef enum logic [1:0] {
        OK         = 2'd0,
        MISALIGNED = 2'd1,
        ILLEGAL    = 2'd2
    } lsu_err_t;

    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LD  = 3'b011,
        LBU = 3'b100,
        LHU = 3'b101,
        LWU = 3'b110
    } load_funct3_t;

    typedef enum logic [2:0] {
        SB = 3'b000,
        SH = 3'b001,
        SW = 3'b010,
        SD = 3'b011
    } store_funct3_t;

    // Doubleword and unsigned-word forms exist only on the 64-bit core.
    function automatic logic f3_legal(
        input logic        store,
        input logic [2:0]  f3,
        input int unsigned xlen
    );
        logic ok;
        ok = 1'b0;
        if (store) begin
            ok = !f3[2] && ((f3[1:0] != 2'b11) || (xlen == 64));
        end else begin
            unique case (f3)
                LB, LH, LW, LBU, LHU: ok = 1'b1;
                LD, LWU:              ok = (xlen == 64);
                default:              ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

    function automatic logic is_misaligned(
        input logic [1:0] size,
        input logic [2:0] low
    );
        logic bad;
        bad = 1'b0;
        unique case (size)
            2'd0: bad = 1'b0;
            2'd1: bad = low[0];
            2'd2: bad = |low[1:0];
            2'd3: bad = |low;
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request, memory and response bundle of the load/store unit.
interface mem_access_unit_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
);
    localparam int NB = XLEN / 8;

    logic              req_valid;
    logic              req_ready;
    logic              req_store;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [XLEN-1:0]   req_wdata;

    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_address;
    logic [NB-1:0]     mem_byte_enable;
    logic [XLEN-1:0]   mem_wdata;
    logic [XLEN-1:0]   mem_rdata;
    logic              mem_resp;

    logic              rsp_valid;
    logic [XLEN-1:0]   rsp_rdata;
    logic [1:0]        rsp_error;

    modport master (
        output req_valid, req_store, req_funct3, req_addr, req_wdata,
        output mem_rdata, mem_resp,
        input  req_ready,
        input  mem_read, mem_write, mem_address, mem_byte_enable, mem_wdata,
        input  rsp_valid, rsp_rdata, rsp_error
    );

    modport slave (
        input  req_valid, req_store, req_funct3, req_addr, req_wdata,
        input  mem_rdata, mem_resp,
        output req_ready,
        output mem_read, mem_write, mem_address, mem_byte_enable, mem_wdata,
        output rsp_valid, rsp_rdata, rsp_error
    );

endinterface

// File: rtl/mem_access_unit_load_align.sv
// Lane select and sign/zero extension of returned load data.
module load_align
    import mem_access_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]                  funct3,
    input  logic [$clog2(XLEN/8)-1:0]   offset,
    input  logic [XLEN-1:0]             word,
    output logic [XLEN-1:0]             result
);
    localparam int OW = $clog2(XLEN / 8);

    logic [XLEN-1:0] shifted;

    assign shifted = word >> {offset, 3'b000};

    always_comb begin
        result = '0;
        unique case (funct3)
            LB:  result = XLEN'($signed(shifted[7:0]));
            LH:  result = XLEN'($signed(shifted[15:0]));
            LW:  result = XLEN'($signed(shifted[31:0]));
            LBU: result = XLEN'(shifted[7:0]);
            LHU: result = XLEN'(shifted[15:0]);
            LWU: result = XLEN'(shifted[31:0]);
            LD:  result = (XLEN == 64) ? shifted : '0;
            default: result = '0;
        endcase
    end

    logic unused_ow;
    assign unused_ow = (OW == 0);

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit: request decode, registered memory strobes, response pulse.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input logic            clk,
    input logic            rst,
    mem_access_unit_if.slave bus
);
    localparam int NB = XLEN / 8;
    localparam int OW = $clog2(NB);

    lsu_state_t        state, state_d;
    lsu_err_t          err_q, err_d;
    logic              store_q, store_d;
    logic [2:0]        f3_q, f3_d;
    logic [OW-1:0]     off_q, off_d;
    logic              read_q, read_d;
    logic              write_q, write_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [NB-1:0]     be_q, be_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [XLEN-1:0]   rdata_q, rdata_d;

    logic              legal;
    logic              misal;
    logic [7:0]        size_mask;
    logic [NB-1:0]     be_req;
    logic [XLEN-1:0]   rep;
    logic [XLEN-1:0]   load_val;

    load_align #(
        .XLEN(XLEN)
    ) u_align (
        .funct3 (f3_q),
        .offset (off_q),
        .word   (bus.mem_rdata),
        .result (load_val)
    );

    // Decode of the incoming request, consumed only on acceptance.
    always_comb begin
        legal     = f3_legal(bus.req_store, bus.req_funct3, XLEN);
        misal     = is_misaligned(bus.req_funct3[1:0], bus.req_addr[2:0]);
        size_mask = 8'h01;
        rep       = bus.req_wdata;
        unique case (bus.req_funct3[1:0])
            2'd0: begin
                size_mask = 8'h01;
                rep       = {NB{bus.req_wdata[7:0]}};
            end
            2'd1: begin
                size_mask = 8'h03;
                rep       = {(NB/2){bus.req_wdata[15:0]}};
            end
            2'd2: begin
                size_mask = 8'h0f;
                rep       = {(NB/4){bus.req_wdata[31:0]}};
            end
            2'd3: begin
                size_mask = 8'hff;
                rep       = bus.req_wdata;
            end
            default: begin
                size_mask = 8'h01;
                rep       = bus.req_wdata;
            end
        endcase
        be_req = NB'(size_mask) << bus.req_addr[OW-1:0];
    end

    always_comb begin
        state_d = state;
        err_d   = err_q;
        store_d = store_q;
        f3_d    = f3_q;
        off_d   = off_q;
        read_d  = read_q;
        write_d = write_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        unique case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    store_d = bus.req_store;
                    f3_d    = bus.req_funct3;
                    off_d   = bus.req_addr[OW-1:0];
                    if (!legal) begin
                        state_d = DONE;
                        err_d   = ILLEGAL;
                        rdata_d = '0;
                    end else if (misal) begin
                        state_d = DONE;
                        err_d   = MISALIGNED;
                        rdata_d = '0;
                    end else begin
                        state_d = ACCESS;
                        read_d  = !bus.req_store;
                        write_d = bus.req_store;
                        addr_d  = {bus.req_addr[ADDR_W-1:OW], {OW{1'b0}}};
                        be_d    = bus.req_store ? be_req : '1;
                        wdata_d = rep;
                    end
                end
            end
            ACCESS: begin
                if (bus.mem_resp) begin
                    state_d = DONE;
                    read_d  = 1'b0;
                    write_d = 1'b0;
                    err_d   = OK;
                    rdata_d = store_q ? '0 : load_val;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            err_q   <= OK;
            store_q <= 1'b0;
            f3_q    <= '0;
            off_q   <= '0;
            read_q  <= 1'b0;
            write_q <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state   <= state_d;
            err_q   <= err_d;
            store_q <= store_d;
            f3_q    <= f3_d;
            off_q   <= off_d;
            read_q  <= read_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    assign bus.req_ready       = (state == IDLE);
    assign bus.rsp_valid       = (state == DONE);
    assign bus.rsp_error       = err_q;
    assign bus.rsp_rdata       = rdata_q;
    assign bus.mem_read        = read_q;
    assign bus.mem_write       = write_q;
    assign bus.mem_address     = addr_q;
    assign bus.mem_byte_enable = be_q;
    assign bus.mem_wdata       = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomised and directed bench for mem_access_unit at XLEN 32 and 64.
module tb_mem_access_unit;

    logic clk;
    logic rst32;
    logic rst64;

    mem_access_unit_if #(.XLEN(32), .ADDR_W(32)) b32 ();
    mem_access_unit_if #(.XLEN(64), .ADDR_W(32)) b64 ();

    mem_access_unit #(.XLEN(32), .ADDR_W(32)) u32 (
        .clk (clk),
        .rst (rst32),
        .bus (b32.slave)
    );

    mem_access_unit #(.XLEN(64), .ADDR_W(32)) u64 (
        .clk (clk),
        .rst (rst64),
        .bus (b64.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit chk_on = 1'b0;

    logic        e_ready [2];
    logic        e_read  [2];
    logic        e_write [2];
    logic        e_rv    [2];
    logic        e_chkmem[2];
    logic        e_chkwd [2];
    logic [31:0] e_addr  [2];
    logic [7:0]  e_be    [2];
    logic [63:0] e_wd    [2];
    logic [63:0] e_rdata [2];
    logic [1:0]  e_err   [2];

    task automatic chk(input string nm, input int s,
                       input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s x%0d: got %h expected %h", nm,
                     (s == 0) ? 32 : 64, a, e);
        end
    endtask

    // Reference: what one request must produce, from the ISA rules.
    function automatic void model(
        input  int          xl,
        input  bit          st,
        input  logic [2:0]  f3,
        input  logic [31:0] addr,
        input  logic [63:0] wd_in,
        input  logic [63:0] rd_in,
        output logic [1:0]  err,
        output logic [7:0]  be,
        output logic [63:0] mwd,
        output logic [63:0] rr
    );
        int nb, size, off;
        bit sgn, legal;
        logic [63:0] wd, rd, v, mask;
        nb = xl / 8;
        wd = (xl == 32) ? (wd_in & 64'hffff_ffff) : wd_in;
        rd = (xl == 32) ? (rd_in & 64'hffff_ffff) : rd_in;
        err = 0; be = 0; mwd = 0; rr = 0;
        legal = 1; sgn = 0; size = 1;
        if (st) begin
            case (f3)
                3'd0: size = 1;
                3'd1: size = 2;
                3'd2: size = 4;
                3'd3: begin size = 8; legal = (xl == 64); end
                default: legal = 0;
            endcase
        end else begin
            case (f3)
                3'd0: begin size = 1; sgn = 1; end
                3'd1: begin size = 2; sgn = 1; end
                3'd2: begin size = 4; sgn = 1; end
                3'd3: begin size = 8; legal = (xl == 64); end
                3'd4: size = 1;
                3'd5: size = 2;
                3'd6: begin size = 4; legal = (xl == 64); end
                default: legal = 0;
            endcase
        end
        if (!legal) begin err = 2; return; end
        if (addr % size != 0) begin err = 1; return; end
        off = addr % nb;
        be = st ? 8'(((1 << size) - 1) << off) : 8'((1 << nb) - 1);
        if (st) for (int i = 0; i < nb; i++) mwd[8*i +: 8] = wd[8*(i%size) +: 8];
        if (!st) begin
            v = rd >> (8 * off);
            mask = (size == 8) ? '1 : (64'd1 << (8 * size)) - 1;
            v = v & mask;
            if (sgn && v[8*size-1]) v = v | ~mask;
            if (xl == 32) v = v & 64'hffff_ffff;
            rr = v;
        end
    endfunction

    task automatic cmp(input int s, input logic rdy, input logic rd,
                       input logic wr, input logic [31:0] ad,
                       input logic [7:0] be, input logic [63:0] wd,
                       input logic rv, input logic [63:0] rr,
                       input logic [1:0] er);
        chk("req_ready", s, rdy, e_ready[s]);
        chk("mem_read", s, rd, e_read[s]);
        chk("mem_write", s, wr, e_write[s]);
        chk("rsp_valid", s, rv, e_rv[s]);
        chk("rsp_rdata", s, rr, e_rdata[s]);
        chk("rsp_error", s, er, e_err[s]);
        if (e_chkmem[s]) begin
            chk("mem_address", s, ad, e_addr[s]);
            chk("mem_byte_enable", s, be, e_be[s]);
        end
        if (e_chkwd[s]) chk("mem_wdata", s, wd, e_wd[s]);
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            cmp(0, b32.req_ready, b32.mem_read, b32.mem_write,
                b32.mem_address, 8'(b32.mem_byte_enable),
                64'(b32.mem_wdata), b32.rsp_valid,
                64'(b32.rsp_rdata), b32.rsp_error);
            cmp(1, b64.req_ready, b64.mem_read, b64.mem_write,
                b64.mem_address, b64.mem_byte_enable,
                b64.mem_wdata, b64.rsp_valid,
                b64.rsp_rdata, b64.rsp_error);
        end
    end

    task automatic drive_req(input int s, input logic v, input logic st,
                             input logic [2:0] f3, input logic [31:0] a,
                             input logic [63:0] wd);
        if (s == 0) begin
            b32.req_valid = v; b32.req_store = st; b32.req_funct3 = f3;
            b32.req_addr = a; b32.req_wdata = wd[31:0];
        end else begin
            b64.req_valid = v; b64.req_store = st; b64.req_funct3 = f3;
            b64.req_addr = a; b64.req_wdata = wd;
        end
    endtask

    task automatic drive_mem(input int s, input logic r, input logic [63:0] d);
        if (s == 0) begin b32.mem_resp = r; b32.mem_rdata = d[31:0]; end
        else begin b64.mem_resp = r; b64.mem_rdata = d; end
    endtask

    task automatic junk_req(input int s, input logic v);
        drive_req(s, v, 1'($urandom), 3'($urandom), $urandom,
                  {$urandom, $urandom});
    endtask

    task automatic reset_exp(input int s);
        e_ready[s] = 1; e_read[s] = 0; e_write[s] = 0; e_rv[s] = 0;
        e_chkmem[s] = 1; e_chkwd[s] = 1; e_addr[s] = 0; e_be[s] = 0;
        e_wd[s] = 0; e_rdata[s] = 0; e_err[s] = 0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Called one step after an edge with the unit idle; returns the same way.
    task automatic do_op(input int s, input bit st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [63:0] wd,
                         input logic [63:0] rd, input int n);
        logic [1:0] err; logic [7:0] be; logic [63:0] mwd, rr;
        int nb;
        nb = (s == 0) ? 4 : 8;
        model((s == 0) ? 32 : 64, st, f3, a, wd, rd, err, be, mwd, rr);
        drive_req(s, 1, st, f3, a, wd);
        drive_mem(s, 1'($urandom), {$urandom, $urandom});
        tick();
        e_ready[s] = 0;
        if (err != 0) begin
            junk_req(s, 0);
            drive_mem(s, 1'($urandom), {$urandom, $urandom});
            e_rv[s] = 1; e_err[s] = err; e_rdata[s] = 0;
            e_chkmem[s] = 0; e_chkwd[s] = 0;
            tick();
        end else begin
            e_read[s] = !st; e_write[s] = st;
            e_addr[s] = a & ~(nb - 1); e_be[s] = be; e_wd[s] = mwd;
            e_chkmem[s] = 1; e_chkwd[s] = st;
            for (int j = 0; j <= n; j++) begin
                junk_req(s, 1'($urandom));
                drive_mem(s, j == n, (j == n) ? rd : {$urandom, $urandom});
                tick();
            end
            junk_req(s, 0);
            drive_mem(s, 1'($urandom), {$urandom, $urandom});
            e_read[s] = 0; e_write[s] = 0; e_chkmem[s] = 0; e_chkwd[s] = 0;
            e_rv[s] = 1; e_err[s] = 0; e_rdata[s] = st ? 64'd0 : rr;
            tick();
        end
        e_rv[s] = 0; e_ready[s] = 1;
        drive_mem(s, 0, 0);
    endtask

    task automatic idle(input int s, input int k);
        for (int i = 0; i < k; i++) begin
            drive_mem(s, 1'($urandom), {$urandom, $urandom});
            tick();
        end
        drive_mem(s, 0, 0);
    endtask

    task automatic set_rst(input int s, input logic v);
        if (s == 0) rst32 = v; else rst64 = v;
    endtask

    task automatic mid_reset(input int s);
        drive_req(s, 1, 0, 3'd2, 32'h40, 0);
        drive_mem(s, 0, 0);
        tick();
        junk_req(s, 0);
        e_ready[s] = 0; e_read[s] = 1; e_write[s] = 0;
        e_addr[s] = 32'h40; e_be[s] = (s == 0) ? 8'h0f : 8'hff;
        e_chkmem[s] = 1; e_chkwd[s] = 0;
        tick();
        set_rst(s, 0);
        tick();
        reset_exp(s);
        tick();
        set_rst(s, 1);
        drive_mem(s, 1, {$urandom, $urandom});
        tick();
        drive_mem(s, 0, 0);
        tick();
    endtask

    initial begin
        logic [1:0] err; logic [7:0] be; logic [63:0] mwd, rr;
        rst32 = 0; rst64 = 0;
        for (int s = 0; s < 2; s++) begin
            drive_req(s, 0, 0, 0, 0, 0);
            drive_mem(s, 0, 0);
            reset_exp(s);
        end
        tick();
        chk_on = 1;
        tick();
        rst32 = 1; rst64 = 1;
        tick();

        model(32, 1, 3'd0, 32'h1003, 64'hab, 0, err, be, mwd, rr);
        chk("pin_sb_be", 0, be, 8'h08);
        chk("pin_sb_wdata", 0, mwd, 64'habab_abab);
        model(32, 0, 3'd1, 32'h2002, 0, 64'h8001_7fff, err, be, mwd, rr);
        chk("pin_lh", 0, rr, 64'hffff_8001);
        model(32, 0, 3'd5, 32'h2002, 0, 64'h8001_7fff, err, be, mwd, rr);
        chk("pin_lhu", 0, rr, 64'h0000_8001);
        model(64, 0, 3'd3, 32'h8, 0, 64'h8000_0000_0000_0001, err, be, mwd, rr);
        chk("pin_ld", 1, rr, 64'h8000_0000_0000_0001);
        model(64, 1, 3'd3, 32'hc, 0, 0, err, be, mwd, rr);
        chk("pin_sd_mis", 1, err, 2'd1);
        model(64, 0, 3'd7, 32'h0, 0, 0, err, be, mwd, rr);
        chk("pin_f3_7", 1, err, 2'd2);

        do_op(0, 1, 3'd0, 32'h1003, 64'hab, 0, 3);
        do_op(0, 0, 3'd1, 32'h2002, 0, 64'h8001_7fff, 0);
        do_op(0, 0, 3'd5, 32'h2002, 0, 64'h8001_7fff, 1);
        do_op(0, 0, 3'd2, 32'h3001, 0, 0, 0);
        do_op(0, 0, 3'd3, 32'h0, 0, 0, 0);
        do_op(0, 1, 3'd3, 32'h0, 0, 0, 0);
        do_op(1, 0, 3'd3, 32'h8, 0, 64'h8000_0000_0000_0001, 2);
        do_op(1, 1, 3'd3, 32'hc, 64'h1234, 0, 0);
        do_op(1, 1, 3'd7, 32'h0, 0, 0, 0);
        do_op(1, 0, 3'd7, 32'h0, 0, 0, 0);
        do_op(1, 0, 3'd6, 32'h4, 0, 64'hf000_0000_8000_0000, 0);
        idle(0, 2);
        mid_reset(0);
        mid_reset(1);

        for (int i = 0; i < 600; i++) begin
            int s; logic [2:0] f3; logic [31:0] a;
            s = $urandom_range(0, 1);
            f3 = 3'($urandom);
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << f3[1:0]) - 1);
            do_op(s, 1'($urandom), f3, a, {$urandom, $urandom},
                  {$urandom, $urandom}, $urandom_range(0, 3));
            if ($urandom_range(0, 2) == 0) idle(s, $urandom_range(1, 2));
        end

        tick();
        chk_on = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
